// File: rtl/pidmc_pkg.sv
// Shared types, default datapath widths and the saturation helper for pid_multi.
// PIDMC_DERIV_EN (defined elsewhere) enables the derivative path in the top module.
package pidmc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_PROD,
        S_ACC,
        S_DONE
    } state_t;

    // Widths for the default build (DATA_W=16, GAIN_W=16); the top derives the same from its parameters
    localparam int DATA_W_DEF = 16;
    localparam int GAIN_W_DEF = 16;
    localparam int ERR_W      = DATA_W_DEF + 1;
    localparam int INT_W      = ERR_W + 1;
    localparam int PROD_W     = INT_W + GAIN_W_DEF + 1;
    localparam int SUM_W      = PROD_W + 2;

    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        logic signed [63:0] r;
        r = value;
        if (value < lo) begin
            r = lo;
        end else if (value > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/pidmc_sat.sv
// Parametrised signed clamp of val_i into [lo_i, hi_i]; used for the integrator and the output.
module pidmc_sat
    import pidmc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] val_i,
    input  logic signed [W-1:0] lo_i,
    input  logic signed [W-1:0] hi_i,
    output logic signed [W-1:0] val_o
);

    assign val_o = W'(sat_signed(64'(val_i), 64'(lo_i), 64'(hi_i)));

endmodule

// File: rtl/pid_multi.sv
// Time-multiplexed multi-channel PID controller sharing one multiply/accumulate datapath.
// Macro PIDMC_DERIV_EN builds the derivative path (eprev storage and kd multiply).
module pid_multi #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 16,
    parameter int GAIN_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int INT_LIM = 4096,
    parameter int MOT_MAX = (1 << (DATA_W - 1)) - 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     clr,
    input  logic [GAIN_W-1:0]        kp,
    input  logic [GAIN_W-1:0]        ki,
    input  logic [GAIN_W-1:0]        kd,
    input  logic signed [DATA_W-1:0] rpm_set   [N_CH],
    input  logic signed [DATA_W-1:0] rpm_sense [N_CH],
    output logic signed [DATA_W-1:0] mot_set   [N_CH],
    output logic                     busy,
    output logic                     done
);
    import pidmc_pkg::*;

    localparam int E_W  = DATA_W + 1;
    localparam int I_W  = E_W + 1;
    localparam int P_W  = I_W + GAIN_W + 1;
    localparam int S_W  = P_W + 2;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic signed [I_W:0]   I_HI = (I_W + 1)'(INT_LIM);
    localparam logic signed [I_W:0]   I_LO = -I_HI;
    localparam logic signed [S_W-1:0] S_HI = S_W'(MOT_MAX);
    localparam logic signed [S_W-1:0] S_LO = '0;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [GAIN_W-1:0]         kp_q, kp_d;
    logic [GAIN_W-1:0]         ki_q, ki_d;
    logic signed [DATA_W-1:0]  set_q [N_CH];
    logic signed [DATA_W-1:0]  set_d [N_CH];
    logic signed [DATA_W-1:0]  sense_q [N_CH];
    logic signed [DATA_W-1:0]  sense_d [N_CH];
    logic signed [I_W-1:0]     integ_q [N_CH];
    logic signed [I_W-1:0]     integ_d [N_CH];
    logic signed [DATA_W-1:0]  mot_q [N_CH];
    logic signed [DATA_W-1:0]  mot_d [N_CH];
    logic signed [E_W-1:0]     e_q, e_d;
    logic signed [I_W-1:0]     inext_q, inext_d;
    logic signed [P_W-1:0]     p_q, p_d;
    logic signed [P_W-1:0]     i_q, i_d;
    logic signed [P_W-1:0]     dt_val;

    logic signed [E_W-1:0]     e_calc;
    logic signed [I_W:0]       isum;
    logic signed [I_W:0]       isat;
    logic signed [S_W-1:0]     acc_sum;
    logic signed [S_W-1:0]     acc_shift;
    logic signed [S_W-1:0]     osat;

`ifdef PIDMC_DERIV_EN
    logic [GAIN_W-1:0]         kd_q, kd_d;
    logic signed [E_W-1:0]     eprev_q [N_CH];
    logic signed [E_W-1:0]     eprev_d [N_CH];
    logic signed [I_W-1:0]     dlt_q, dlt_d;
    logic signed [I_W-1:0]     dlt_calc;
    logic signed [P_W-1:0]     dt_q, dt_d;

    assign dlt_calc = I_W'(e_calc) - I_W'(eprev_q[ch_q]);
    assign dt_val   = dt_q;
`else
    logic unused_kd;

    assign unused_kd = ^kd;
    assign dt_val    = '0;
`endif

    assign e_calc    = E_W'(set_q[ch_q]) - E_W'(sense_q[ch_q]);
    assign isum      = (I_W + 1)'(integ_q[ch_q]) + (I_W + 1)'(e_calc);
    assign acc_sum   = S_W'(p_q) + S_W'(i_q) + S_W'(dt_val);
    assign acc_shift = acc_sum >>> FRAC_W;

    pidmc_sat #(.W(I_W + 1)) u_int_sat (
        .val_i (isum),
        .lo_i  (I_LO),
        .hi_i  (I_HI),
        .val_o (isat)
    );

    pidmc_sat #(.W(S_W)) u_out_sat (
        .val_i (acc_shift),
        .lo_i  (S_LO),
        .hi_i  (S_HI),
        .val_o (osat)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kp_d    = kp_q;
        ki_d    = ki_q;
        set_d   = set_q;
        sense_d = sense_q;
        integ_d = integ_q;
        mot_d   = mot_q;
        e_d     = e_q;
        inext_d = inext_q;
        p_d     = p_q;
        i_d     = i_q;
`ifdef PIDMC_DERIV_EN
        kd_d    = kd_q;
        eprev_d = eprev_q;
        dlt_d   = dlt_q;
        dt_d    = dt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Clear lands in the same edge as a start, so the new pass sees zeroed state
                if (clr) begin
                    for (int i = 0; i < N_CH; i++) begin
                        integ_d[i] = '0;
`ifdef PIDMC_DERIV_EN
                        eprev_d[i] = '0;
`endif
                    end
                end
                if (start) begin
                    kp_d    = kp;
                    ki_d    = ki;
`ifdef PIDMC_DERIV_EN
                    kd_d    = kd;
`endif
                    set_d   = rpm_set;
                    sense_d = rpm_sense;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                e_d     = e_calc;
                inext_d = I_W'(isat);
`ifdef PIDMC_DERIV_EN
                dlt_d   = dlt_calc;
`endif
                state_d = S_PROD;
            end
            S_PROD: begin
                p_d     = P_W'(e_q) * P_W'($signed({1'b0, kp_q}));
                i_d     = P_W'(inext_q) * P_W'($signed({1'b0, ki_q}));
`ifdef PIDMC_DERIV_EN
                dt_d    = P_W'(dlt_q) * P_W'($signed({1'b0, kd_q}));
`endif
                state_d = S_ACC;
            end
            S_ACC: begin
                mot_d[ch_q]   = DATA_W'(osat);
                integ_d[ch_q] = inext_q;
`ifdef PIDMC_DERIV_EN
                eprev_d[ch_q] = e_q;
`endif
                if (ch_q == CH_W'(N_CH - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kp_q    <= '0;
            ki_q    <= '0;
            e_q     <= '0;
            inext_q <= '0;
            p_q     <= '0;
            i_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                set_q[i]   <= '0;
                sense_q[i] <= '0;
                integ_q[i] <= '0;
                mot_q[i]   <= '0;
`ifdef PIDMC_DERIV_EN
                eprev_q[i] <= '0;
`endif
            end
`ifdef PIDMC_DERIV_EN
            kd_q    <= '0;
            dlt_q   <= '0;
            dt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kp_q    <= kp_d;
            ki_q    <= ki_d;
            e_q     <= e_d;
            inext_q <= inext_d;
            p_q     <= p_d;
            i_q     <= i_d;
            set_q   <= set_d;
            sense_q <= sense_d;
            integ_q <= integ_d;
            mot_q   <= mot_d;
`ifdef PIDMC_DERIV_EN
            kd_q    <= kd_d;
            eprev_q <= eprev_d;
            dlt_q   <= dlt_d;
            dt_q    <= dt_d;
`endif
        end
    end

    assign mot_set = mot_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pid_multi.sv
// Self-checking bench for pid_multi: a default instance and one with INT_LIM=1000, checked against an arithmetic model.
module tb_pid_multi;

    localparam int N = 4;
`ifdef PIDMC_DERIV_EN
    localparam bit DERIV = 1'b1;
`else
    localparam bit DERIV = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic [15:0] kp = '0;
    logic [15:0] ki = '0;
    logic [15:0] kd = '0;
    logic signed [15:0] rpm_set [N];
    logic signed [15:0] rpm_sense [N];
    logic signed [15:0] mot_a [N];
    logic signed [15:0] mot_b [N];
    logic busy_a, done_a, busy_b, done_b;

    int n_chk = 0;
    int n_err = 0;
    int set_v [N];
    int sense_v [N];
    longint m_integ [2][N];
    longint m_eprev [2][N];
    longint m_mot [2][N];
    longint old_mot [2][N];

    pid_multi u_dut (
        .clk(clk), .reset(reset), .start(start), .clr(clr),
        .kp(kp), .ki(ki), .kd(kd),
        .rpm_set(rpm_set), .rpm_sense(rpm_sense),
        .mot_set(mot_a), .busy(busy_a), .done(done_a)
    );

    pid_multi #(.INT_LIM(1000)) u_lim (
        .clk(clk), .reset(reset), .start(start), .clr(clr),
        .kp(kp), .ki(ki), .kd(kd),
        .rpm_set(rpm_set), .rpm_sense(rpm_sense),
        .mot_set(mot_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lim_of(input int k);
        return (k == 0) ? 64'sd4096 : 64'sd1000;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) begin
                m_integ[k][c] = 0;
                m_eprev[k][c] = 0;
            end
    endtask

    task automatic model_reset();
        model_clear();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) m_mot[k][c] = 0;
    endtask

    task automatic model_pass(input longint gp, input longint gi, input longint gd);
        longint e, in_v, d, s;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) begin
                e = longint'(set_v[c]) - longint'(sense_v[c]);
                in_v = m_integ[k][c] + e;
                if (in_v > lim_of(k)) in_v = lim_of(k);
                if (in_v < -lim_of(k)) in_v = -lim_of(k);
                d = DERIV ? (e - m_eprev[k][c]) : 0;
                s = (gp * e + gi * in_v + gd * d) >>> 8;
                if (s < 0) s = 0;
                if (s > 32767) s = 32767;
                m_mot[k][c] = s;
                m_integ[k][c] = in_v;
                m_eprev[k][c] = e;
            end
    endtask

    task automatic set_all(input int s, input int n);
        for (int c = 0; c < N; c++) begin
            set_v[c] = s;
            sense_v[c] = n;
        end
    endtask

    task automatic set_rand();
        for (int c = 0; c < N; c++) begin
            set_v[c] = int'($urandom_range(0, 65535)) - 32768;
            sense_v[c] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic scramble();
        kp = 16'($urandom);
        ki = 16'($urandom);
        kd = 16'($urandom);
        for (int c = 0; c < N; c++) begin
            rpm_set[c] = 16'($urandom);
            rpm_sense[c] = 16'($urandom);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("clr_hold_a[%0d]", c), mot_a[c], m_mot[0][c]);
            chk($sformatf("clr_hold_b[%0d]", c), mot_b[c], m_mot[1][c]);
        end
        chk("clr_busy", busy_a, 0);
    endtask

    task automatic run_pass(input int gp, input int gi, input int gd, input bit with_clr, input bit poke);
        @(negedge clk);
        kp = 16'(gp);
        ki = 16'(gi);
        kd = 16'(gd);
        for (int c = 0; c < N; c++) begin
            rpm_set[c] = 16'(set_v[c]);
            rpm_sense[c] = 16'(sense_v[c]);
        end
        clr = with_clr;
        start = 1'b1;
        old_mot = m_mot;
        if (with_clr) model_clear();
        model_pass(longint'(gp), longint'(gi), longint'(gd));
        @(posedge clk);
        #1;
        start = 1'b0;
        clr = 1'b0;
        scramble();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                chk($sformatf("mot_a[%0d]@%0d", c, k), mot_a[c], (k >= 3 * c + 3) ? m_mot[0][c] : old_mot[0][c]);
                chk($sformatf("mot_b[%0d]@%0d", c, k), mot_b[c], (k >= 3 * c + 3) ? m_mot[1][c] : old_mot[1][c]);
            end
            chk($sformatf("busy_a@%0d", k), busy_a, (k <= 12) ? 1 : 0);
            chk($sformatf("done_a@%0d", k), done_a, (k == 12) ? 1 : 0);
            chk($sformatf("busy_b@%0d", k), busy_b, (k <= 12) ? 1 : 0);
            chk($sformatf("done_b@%0d", k), done_b, (k == 12) ? 1 : 0);
            if (poke && k == 4) begin
                start = 1'b1;
                clr = 1'b1;
            end
            if (poke && k == 5) begin
                start = 1'b0;
                clr = 1'b0;
            end
        end
        @(negedge clk);
        chk("idle_busy_a", busy_a, 0);
        chk("idle_busy_b", busy_b, 0);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            rpm_set[c] = '0;
            rpm_sense[c] = '0;
        end
        set_all(0, 0);
        model_reset();

        repeat (2) @(negedge clk);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("rst_mot_a[%0d]", c), mot_a[c], 0);
            chk($sformatf("rst_mot_b[%0d]", c), mot_b[c], 0);
        end
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        reset = 1'b0;

        // proportional only, then both output clamps
        set_all(1000, 400);
        run_pass(256, 0, 0, 1'b0, 1'b0);
        chk("kp_600_ch0", mot_a[0], 600);
        chk("kp_600_ch3", mot_a[3], 600);
        set_all(400, 1000);
        run_pass(256, 0, 0, 1'b0, 1'b0);
        chk("clamp_lo", mot_a[2], 0);
        set_all(32767, -32768);
        run_pass(256, 0, 0, 1'b0, 1'b0);
        chk("clamp_hi", mot_a[1], 32767);

        // integral accumulation and clear
        do_clr();
        set_all(100, 0);
        for (int p = 0; p < 3; p++) run_pass(0, 256, 0, 1'b0, 1'b0);
        chk("int_300", mot_a[0], 300);
        do_clr();
        run_pass(0, 256, 0, 1'b0, 1'b0);
        chk("int_after_clr", mot_a[3], 100);

        // anti-windup on the INT_LIM=1000 instance
        do_clr();
        set_all(600, 0);
        for (int p = 0; p < 3; p++) run_pass(0, 256, 0, 1'b0, 1'b0);
        chk("windup_cap", mot_b[0], 1000);
        chk("no_cap_dflt", mot_a[0], 1800);
        set_all(0, 100);
        run_pass(0, 256, 0, 1'b0, 1'b0);
        chk("unwind_900", mot_b[1], 900);

        // derivative path
        do_clr();
        set_all(0, 0);
        run_pass(0, 0, 256, 1'b0, 1'b0);
        set_all(50, 0);
        run_pass(0, 0, 256, 1'b0, 1'b0);
        chk("deriv_step", mot_a[0], DERIV ? 50 : 0);
        run_pass(0, 0, 256, 1'b0, 1'b0);
        chk("deriv_flat", mot_a[0], 0);

        // start/clr while busy are ignored
        for (int p = 0; p < 3; p++) begin
            set_rand();
            run_pass(int'($urandom_range(0, 1023)), int'($urandom_range(0, 300)),
                     int'($urandom_range(0, 300)), 1'b0, 1'b1);
        end

        // clr together with start
        set_all(300, 100);
        run_pass(0, 256, 0, 1'b1, 1'b0);
        chk("clr_start", mot_a[0], 200);

        for (int p = 0; p < 8; p++) begin
            set_rand();
            if (p % 3 == 0) begin
                for (int c = 0; c < N; c++) sense_v[c] = set_v[c] / 2 - int'($urandom_range(0, 2000));
            end
            run_pass(int'($urandom_range(0, 65535)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)), (p == 5), (p == 2));
        end

        // asynchronous reset in the middle of a pass
        set_all(1000, 400);
        @(negedge clk);
        kp = 16'd256;
        ki = 16'd16;
        kd = 16'd0;
        for (int c = 0; c < N; c++) begin
            rpm_set[c] = 16'(set_v[c]);
            rpm_sense[c] = 16'(sense_v[c]);
        end
        start = 1'b1;
        model_pass(256, 16, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_ch0", mot_a[0], m_mot[0][0]);
        reset = 1'b1;
        #1;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("midrst_a[%0d]", c), mot_a[c], 0);
            chk($sformatf("midrst_b[%0d]", c), mot_b[c], 0);
        end
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy_a, 0);

        set_all(500, 100);
        run_pass(256, 256, 0, 1'b0, 1'b0);
        chk("post_rst_pass", mot_a[0], 800);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pid_multi.md
# pid_multi

Time-multiplexed, parametrised multi-channel PID motor controller. Computes a drive reference `mot_set` per motor from the desired RPM (`rpm_set`) and the measured RPM (`rpm_sense`). All channels share one arithmetic datapath. Sits between the directional controller and the motor drivers, and replaces the single-channel fixed-gain compensator with runtime gains, integrator anti-windup and output saturation.

## Interface
- `N_CH`, 4: number of motor channels.
- `DATA_W`, 16: signed width of the RPM inputs and the `mot_set` outputs.
- `GAIN_W`, 16: unsigned gain width.
- `FRAC_W`, 8: fractional bits of the gains. 1.0 is `1<<FRAC_W`.
- `INT_LIM`, 4096: integrator clamp magnitude, range `[-INT_LIM, +INT_LIM]`.
- `MOT_MAX`, 2^(DATA_W-1)-1: upper saturation bound of `mot_set`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request one update pass over all channels.
- `clr` in 1: clear integrators and previous-error state.
- `kp`, `ki`, `kd` in GAIN_W each: unsigned gains, sampled on the accepted `start`.
- `rpm_set` in [N_CH][DATA_W]: signed desired RPM per channel.
- `rpm_sense` in [N_CH][DATA_W]: signed measured RPM per channel.
- `mot_set` out [N_CH][DATA_W]: signed drive reference, always within `[0, MOT_MAX]`.
- `busy` out 1: high while a pass is in progress.
- `done` out 1: one-cycle pulse when a pass completes.

## Operation
- FSM states: IDLE, ERR, PROD, ACC, DONE.
- IDLE: `start` is accepted here only. On acceptance, snapshot gains, `rpm_set` and `rpm_sense`, set ch=0, go to ERR.
- ERR: e = rpm_set[ch] - rpm_sense[ch], computed at DATA_W+1 bits. i_next = clamp(integ[ch] + e, ±INT_LIM). d = e - eprev[ch].
- PROD: register p = kp*e, i = ki*i_next, d_t = kd*d. Full-precision signed products.
- ACC: sum = (p + i + d_t) >>> FRAC_W, arithmetic shift. mot_set[ch] = sum clamped to [0, MOT_MAX]. Then integ[ch] <= i_next and eprev[ch] <= e. If ch == N_CH-1 go to DONE, else ch+1 and go to ERR.
- DONE: `done`=1 for one cycle, then IDLE.
- Anti-windup: the integrator is clamped. It is not frozen on output saturation.
- `clr` in IDLE zeroes every `integ` and `eprev` in that cycle. `mot_set` is unchanged.
- `clr` and `start` in the same IDLE cycle: the clear applies first, and the pass uses zeroed state.
- `start` or `clr` while `busy`: ignored. No queuing.
- Channels not yet updated in a pass hold their previous `mot_set`.

## Timing
- Reset values: `mot_set`=0 on all channels, `busy`=0, `done`=0, all `integ`/`eprev`=0, FSM=IDLE. Reset takes effect immediately and asynchronously, including mid-pass. The partial pass is discarded.
- `start` is sampled at edge T0. `busy` is high from T0+1 through the DONE cycle.
- Channel c's `mot_set` updates at edge T0+3c+3.
- `done` is high during cycle T0+3*N_CH+1. The next `start` can be accepted at edge T0+3*N_CH+2.
- Inputs may change freely after T0. Only the snapshot is used.

## Configuration
- `PIDMC_DERIV_EN` defined: the derivative path, `eprev` storage and `kd` multiply are built as described above.
- Undefined: d_t is 0, `eprev` is not instantiated, and `kd` is accepted but unused. FSM timing is identical.

## Structure
- Package `pidmc_pkg`: `state_t` enum, and width localparams (ERR_W=DATA_W+1, INT_W, PROD_W=INT_W+GAIN_W+1, SUM_W).
- The package also holds the function `sat_signed(value, lo, hi)`.
- Sub-module `pidmc_sat`: parametrised signed clamp, used for both the integrator clamp and the output clamp.
- Per-channel state (`integ`, `eprev`, `mot_set`) is held in register arrays indexed by ch. There is a single multiplier per gain.

## Test plan
Defaults apply, with FRAC_W=8.
- kp=256, ki=kd=0; set=1000, sense=400 -> mot_set[ch]=600 on all channels; `done` exactly at T0+13.
- kp=256; set=400, sense=1000 -> mot_set=0 (lower clamp). set=32767, sense=-32768 -> mot_set=32767.
- kp=0, ki=256; error 100, three passes -> 100, 200, 300. Then `clr`, one pass -> 100.
- INT_LIM=1000, ki=256; error 600, three passes -> 600, 1000, 1000. Then error -100 -> 900, with no windup delay.
- With `PIDMC_DERIV_EN`, kd=256, kp=ki=0: errors 0, 50, 50 -> 0, 50, 0. Without the macro -> 0, 0, 0.
- Assert `reset` mid-pass at T0+5 -> `mot_set`=0, `busy`=0 in the same cycle. Also: `start` while busy is ignored, and `clr`+`start` together start from zeroed integrators.
